// File: rtl/ice_counter_top.sv
// Free-running WIDTH-bit up-counter with a reset synchronizer and a clock-enable prescaler.
// Optional macro COUNTER_GRAY_OUT_EN: drive cnt_o with a registered Gray code of the count.
module ice_counter_top #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned DIV         = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] cnt_o
);

  localparam int unsigned PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_n;
  logic [PSC_W-1:0]       psc_q;
  logic                   tick;
  logic [WIDTH-1:0]       cnt_q;

  // Assertion is asynchronous; release ripples through the chain on clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n = sync_q[SYNC_STAGES-1];

  // Gating with rst_n keeps tick low while the synchronizer holds reset.
  assign tick = rst_n & (psc_q == PSC_MAX);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else if (tick) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= cnt_q ^ (cnt_q >> 1);
    end
  end

  assign cnt_o = gray_q;
`else
  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_ice_counter_top.sv
// Directed bench for ice_counter_top: default, DIV=4 and WIDTH=4 instances share clock and reset.
module tb_ice_counter_top;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] cnt_def;
  logic [2:0] cnt_div4;
  logic [3:0] cnt_w4;

  int n_chk  = 0;
  int n_pass = 0;

  ice_counter_top u_def (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt_o  (cnt_def)
  );

  ice_counter_top #(.WIDTH(3), .DIV(4)) u_div4 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt_o  (cnt_div4)
  );

  ice_counter_top #(.WIDTH(4), .DIV(1)) u_w4 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt_o  (cnt_w4)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // k = rising edges seen since rst_ni went high (0 while held in reset).
  // Sync releases on edge 2, first tick lands on edge 3, then one increment per DIV edges.
  function automatic logic [31:0] exp_cnt(input int k, input int div, input int w);
    int b;
    b = 0;
`ifdef COUNTER_GRAY_OUT_EN
    if (k >= 3) begin
      b = ((k - 3) / div) % (1 << w);
      b = b ^ (b >> 1);
    end
`else
    if (k >= 2) begin
      b = ((k - 2) / div) % (1 << w);
    end
`endif
    return b;
  endfunction

  task automatic check_all(input string tag, input int k);
    check({tag, "_def"},  {29'd0, cnt_def},  exp_cnt(k, 1, 3));
    check({tag, "_div4"}, {29'd0, cnt_div4}, exp_cnt(k, 4, 3));
    check({tag, "_w4"},   {28'd0, cnt_w4},   exp_cnt(k, 1, 4));
  endtask

  task automatic run_edges(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk_i);
      #1;
      check_all(tag, k);
    end
  endtask

  initial begin
    #2;
    check_all("in_reset", 0);
    #8;
    rst_ni = 1'b1;

    // Hand-computed opening sequence of the default build.
    @(posedge clk_i); #1;
    check("seq_e1", {29'd0, cnt_def}, 32'd0);
    @(posedge clk_i); #1;
    check("seq_e2", {29'd0, cnt_def}, 32'd0);
    @(posedge clk_i); #1;
`ifdef COUNTER_GRAY_OUT_EN
    check("seq_e3", {29'd0, cnt_def}, 32'd0);
    @(posedge clk_i); #1;
    check("seq_e4", {29'd0, cnt_def}, 32'b001);
    @(posedge clk_i); #1;
    check("seq_e5", {29'd0, cnt_def}, 32'b011);
    @(posedge clk_i); #1;
    check("seq_e6", {29'd0, cnt_def}, 32'b010);
    @(posedge clk_i); #1;
    check("seq_e7", {29'd0, cnt_def}, 32'b110);
`else
    check("seq_e3", {29'd0, cnt_def}, 32'd1);
    @(posedge clk_i); #1;
    check("seq_e4", {29'd0, cnt_def}, 32'd2);
    @(posedge clk_i); #1;
    check("seq_e5", {29'd0, cnt_def}, 32'd3);
    @(posedge clk_i); #1;
    check("seq_e6", {29'd0, cnt_def}, 32'd4);
    @(posedge clk_i); #1;
    check("seq_e7", {29'd0, cnt_def}, 32'd5);
`endif

    // Continue the same run (edges 8..999), about 10 us.
    for (int k = 8; k <= 999; k++) begin
      @(posedge clk_i);
      #1;
      check_all("run", k);
    end

`ifndef COUNTER_GRAY_OUT_EN
    check("pre_rst_is5", {29'd0, cnt_def}, 32'd5);
`endif
    // Mid-count reset must clear outputs with no clock edge in between.
    #2 rst_ni = 1'b0;
    #1;
    check_all("mid_rst", 0);
    @(negedge clk_i);
    @(negedge clk_i);
    check_all("held_rst", 0);
    rst_ni = 1'b1;
    run_edges("restart", 40);

    // Glitch shorter than a clock period still clears everything.
    #1 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    #1;
    check_all("glitch", 0);
    run_edges("post_glitch", 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
